pb_rect_fill: RTL and testbench
===============================

# pb_rect_fill

Hardware rectangle-fill engine between the Nios II command PIOs and the write port of the 160x120, 4-bit pixel buffer (`ram2port`). It accepts one rectangle command at a time and clips it to the frame. It then writes the fill colour into every covered pixel, one pixel per clock, in row-major order. This replaces per-pixel PIO writes from software.

## Interface

Parameters:
- `H_RES`, 160: frame width in pixels.
- `V_RES`, 120: frame height in pixels.

Ports (one clock; reset is synchronous and active-low; the block runs on `VGA_CLK`, the pixel-buffer clock):
- `VGA_CLK`, in, 1: clock. All state changes on the rising edge.
- `RESET_N`, in, 1: synchronous reset, active low.
- `CMD_VALID`, in, 1: a command is present on the `CMD_*` lines.
- `CMD_READY`, out, 1: the engine can accept a command.
- `CMD_X`, in, 8: left column.
- `CMD_Y`, in, 7: top row.
- `CMD_W`, in, 8: width in pixels.
- `CMD_H`, in, 7: height in pixels.
- `CMD_COLOUR`, in, 4: fill colour.
- `PB_WA`, out, 15: pixel-buffer write address, equal to y*`H_RES`+x.
- `PB_DATA`, out, 4: pixel-buffer write data.
- `PB_WE`, out, 1: pixel-buffer write enable.
- `BUSY`, out, 1: high in every state except IDLE.
- `DONE`, out, 1: one-cycle pulse when a command completes.

## Operation

The engine has four states: IDLE, SETUP, FILL and DONE.

- **IDLE:** `CMD_READY`=1. A command is accepted on any edge where `CMD_VALID`&`CMD_READY`. At acceptance, all `CMD_*` fields are latched and the state moves to SETUP.
- **SETUP** (one cycle): clipping is computed.
  - x_end = min(X+W, `H_RES`) and y_end = min(Y+H, `V_RES`), using 9-bit sums (no wrap).
  - The rectangle is empty if W=0, H=0, X≥`H_RES` or Y≥`V_RES`.
  - Empty: go to DONE. Non-empty: load x=X, y=Y, row_base=Y*`H_RES` (formed by shift-add, no multiplier), then go to FILL.
- **FILL:** one write per cycle.
  - `PB_WA`=row_base+x, `PB_DATA`=latched colour, `PB_WE`=1.
  - x increments each cycle. When x+1 = x_end: x reloads to X, y increments and row_base += `H_RES`.
  - When the write at (x_end-1, y_end-1) has been issued, go to DONE.
- **DONE** (one cycle): `DONE`=1 and `CMD_READY`=0, then return to IDLE.

Other rules:
- `CMD_VALID` outside IDLE is ignored. The `CMD_*` inputs may change freely after acceptance.
- Written pixels = (x_end-X)*(y_end-Y). Clipped-off pixels are never written. `PB_WA` never exceeds `H_RES`*`V_RES`-1 (19199).
- Reset mid-operation: the fill stops immediately with no further writes. There is no DONE pulse and the latched command is discarded.

## Timing

- All outputs are registered.
- Reset values: `CMD_READY`=0, `BUSY`=0, `DONE`=0, `PB_WE`=0, `PB_WA`=0, `PB_DATA`=0.
- On the first edge after `RESET_N` rises, the engine enters IDLE with `CMD_READY`=1.
- Acceptance on edge k. `BUSY`=1 and `CMD_READY`=0 from the cycle after k. The first `PB_WE` is high in cycle k+2.
- N writes occupy N consecutive cycles with no gaps, including at row wrap.
- `DONE` is high in cycle k+2+N. `CMD_READY`=1 again in cycle k+3+N.
- For an empty rectangle: `DONE` at k+2 and `CMD_READY` at k+3.
- Back-to-back commands: minimum spacing between acceptances is N+4 cycles.
- `PB_WE` is 0 in every cycle outside FILL. `PB_WA` and `PB_DATA` hold their last values when `PB_WE`=0.
- Timing assumes the `ram2port` write port samples `PB_WA`/`PB_DATA`/`PB_WE` on the same `VGA_CLK` edge. No extra handshake is needed.

## Test plan

- Small rectangle X=10, Y=5, W=3, H=2, colour 0x3 -> writes to addresses 810, 811, 812, 970, 971, 972 with data 3 on 6 consecutive cycles; `DONE` at accept+8.
- Full frame X=0, Y=0, W=160, H=120, colour 0xA -> exactly 19200 writes, addresses 0..19199 ascending with no gaps; `DONE` at accept+19202.
- Clipping X=158, Y=119, W=5, H=4, colour 0xF -> only addresses 19198 and 19199 are written; `DONE` at accept+4.
- Empty commands W=0; then X=200, W=10, H=10 -> no `PB_WE` in either case; each gives `DONE` at accept+2 and `CMD_READY` at accept+3.
- `CMD_VALID` held high with changing fields during a 4x4 fill -> the second command is accepted only after `CMD_READY` returns; the first fill's 16 writes are unaffected.
- `RESET_N` low for 1 cycle during the 5th write of a 4x4 fill -> no writes after reset; `DONE` never pulses; `CMD_READY`=1 on the first edge after release; a new command then fills correctly.

Source files
------------

// File: rtl/pb_rect_fill_if.sv
// Command and pixel-buffer write bundle for pb_rect_fill.
// master = command source / pixel-buffer side, slave = the fill engine.
interface pb_rect_fill_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_X;
    logic [6:0]  CMD_Y;
    logic [7:0]  CMD_W;
    logic [6:0]  CMD_H;
    logic [3:0]  CMD_COLOUR;
    logic [14:0] PB_WA;
    logic [3:0]  PB_DATA;
    logic        PB_WE;
    logic        BUSY;
    logic        DONE;

    modport master (
        output CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOUR,
        input  CMD_READY, PB_WA, PB_DATA, PB_WE, BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOUR,
        output CMD_READY, PB_WA, PB_DATA, PB_WE, BUSY, DONE
    );
endinterface

// File: rtl/pb_rect_fill.sv
// Rectangle-fill engine: clips one command to the frame and writes the fill
// colour into the pixel buffer, one pixel per clock, row-major.
module pb_rect_fill #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input logic           VGA_CLK,
    input logic           RESET_N,
    pb_rect_fill_if.slave bus
);
    localparam logic [8:0]  H_END  = 9'(H_RES);
    localparam logic [7:0]  V_END  = 8'(V_RES);
    localparam logic [14:0] H_STEP = 15'(H_RES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

    state_t      state, state_nxt;

    logic [7:0]  x0, w;
    logic [6:0]  y0, h;
    logic [3:0]  colour;
    logic [8:0]  x_end;
    logic [7:0]  y_end;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] row_base;

    logic [8:0]  x_sum, x_end_c;
    logic [7:0]  y_sum, y_end_c;
    logic        empty, row_last, last_px, accept;

    // Constant multiply by H_RES as a sum of shifted copies of the row index.
    function automatic logic [14:0] row_of(input logic [6:0] yy);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 15; i++)
            if (H_STEP[i]) acc = acc + (15'(yy) << i);
        return acc;
    endfunction

    // NOTE: every signal written here gets a value before any branch, so no latches are inferred.
    always_comb begin
        x_sum     = {1'b0, x0} + {1'b0, w};
        y_sum     = {1'b0, y0} + {1'b0, h};
        x_end_c   = (x_sum > H_END) ? H_END : x_sum;
        y_end_c   = (y_sum > V_END) ? V_END : y_sum;
        empty     = (w == 8'd0) || (h == 7'd0) ||
                    ({1'b0, x0} >= H_END) || ({1'b0, y0} >= V_END);
        row_last  = (({1'b0, x} + 9'd1) == x_end);
        last_px   = row_last && (({1'b0, y} + 8'd1) == y_end);
        accept    = bus.CMD_VALID && bus.CMD_READY && (state == S_IDLE);
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: state_nxt = empty ? S_DONE : S_FILL;
            S_FILL:  if (last_px) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state they describe, so the
    // write for a FILL cycle appears on the port during the following cycle.
    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            bus.CMD_READY <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.PB_WE     <= 1'b0;
            bus.PB_WA     <= '0;
            bus.PB_DATA   <= '0;
        end else begin
            state         <= state_nxt;
            bus.CMD_READY <= (state == S_IDLE) && (state_nxt == S_IDLE);
            bus.BUSY      <= !((state == S_IDLE) && (state_nxt == S_IDLE));
            bus.DONE      <= (state == S_DONE);
            bus.PB_WE     <= (state == S_FILL);
            if (state == S_FILL) begin
                bus.PB_WA   <= row_base + 15'(x);
                bus.PB_DATA <= colour;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before use
    // and the FSM alone decides whether their contents reach the outputs.
    always_ff @(posedge VGA_CLK) begin
        case (state)
            S_IDLE: begin
                if (accept) begin
                    x0     <= bus.CMD_X;
                    y0     <= bus.CMD_Y;
                    w      <= bus.CMD_W;
                    h      <= bus.CMD_H;
                    colour <= bus.CMD_COLOUR;
                end
            end
            S_SETUP: begin
                x_end    <= x_end_c;
                y_end    <= y_end_c;
                x        <= x0;
                y        <= y0;
                row_base <= row_of(y0);
            end
            S_FILL: begin
                if (row_last) begin
                    x        <= x0;
                    y        <= y + 7'd1;
                    row_base <= row_base + H_STEP;
                end else begin
                    x <= x + 8'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pb_rect_fill.sv
// Directed bench for pb_rect_fill: hand-computed clip ranges, write addresses,
// and DONE / CMD_READY cycle offsets relative to the accepting edge.
module tb_pb_rect_fill;
    logic VGA_CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    pb_rect_fill_if bus ();

    pb_rect_fill #(.H_RES(160), .V_RES(120)) dut (
        .VGA_CLK (VGA_CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 VGA_CLK = ~VGA_CLK;
    always @(posedge VGA_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.CMD_X      = 8'($urandom);
        bus.CMD_Y      = 7'($urandom);
        bus.CMD_W      = 8'($urandom);
        bus.CMD_H      = 7'($urandom);
        bus.CMD_COLOUR = 4'($urandom);
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
        bus.CMD_X      = 8'(x);
        bus.CMD_Y      = 7'(y);
        bus.CMD_W      = 8'(w);
        bus.CMD_H      = 7'(h);
        bus.CMD_COLOUR = 4'(c);
        bus.CMD_VALID  = 1'b1;
    endtask

    // Issues one command and checks every write against the clip range
    // [xl..xh] x [yl..yh] (pass xl > xh for an empty rectangle).
    task automatic run_fill(input string tag, input int x, input int y, input int w,
                            input int h, input int c, input int xl, input int xh,
                            input int yl, input int yh, input bit hold,
                            output int acc_cyc);
        int n_exp, t, done_t, nbad, i;
        int wt[$];
        int wa[$];
        int wd[$];
        n_exp = (xl <= xh && yl <= yh) ? (xh - xl + 1) * (yh - yl + 1) : 0;
        t = 0;
        while (!bus.CMD_READY && t < 100) begin
            @(negedge VGA_CLK);
            t++;
        end
        check({tag, " ready before accept"}, int'(bus.CMD_READY), 1);
        drive_cmd(x, y, w, h, c);
        @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        acc_cyc = cyc;
        check({tag, " busy after accept"}, int'(bus.BUSY), 1);
        check({tag, " ready after accept"}, int'(bus.CMD_READY), 0);
        if (!hold) bus.CMD_VALID = 1'b0;
        scramble();
        done_t = -1;
        for (t = 1; t < n_exp + 40 && done_t < 0; t++) begin
            @(negedge VGA_CLK);
            if (hold) scramble();
            if (bus.PB_WE) begin
                wt.push_back(t);
                wa.push_back(int'(bus.PB_WA));
                wd.push_back(int'(bus.PB_DATA));
            end
            if (bus.DONE) done_t = t;
        end
        check({tag, " done seen"}, int'(done_t >= 0), 1);
        check({tag, " done offset"}, done_t, n_exp + 2);
        check({tag, " write count"}, wt.size(), n_exp);
        nbad = 0;
        i = 0;
        for (int yy = yl; yy <= yh; yy++) begin
            for (int xx = xl; xx <= xh; xx++) begin
                if (i < wt.size()) begin
                    if (wt[i] != 2 + i || wa[i] != yy * 160 + xx || wd[i] != c) begin
                        if (nbad == 0)
                            $display("%s first bad write %0d: t=%0d addr=%0d data=%0d, want t=%0d addr=%0d data=%0d",
                                     tag, i, wt[i], wa[i], wd[i], 2 + i, yy * 160 + xx, c);
                        nbad++;
                    end
                end
                i++;
            end
        end
        check({tag, " bad pixels"}, nbad, 0);
        @(negedge VGA_CLK);
        check({tag, " ready returns"}, int'(bus.CMD_READY), 1);
        check({tag, " idle not busy"}, int'(bus.BUSY), 0);
    endtask

    initial begin
        int a0, a1, nw, t, we_cnt, done_cnt, last_wa;
        bus.CMD_VALID = 1'b0;
        drive_cmd(0, 0, 0, 0, 0);
        bus.CMD_VALID = 1'b0;

        repeat (3) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        check("reset CMD_READY", int'(bus.CMD_READY), 0);
        check("reset BUSY", int'(bus.BUSY), 0);
        check("reset DONE", int'(bus.DONE), 0);
        check("reset PB_WE", int'(bus.PB_WE), 0);
        check("reset PB_WA", int'(bus.PB_WA), 0);
        check("reset PB_DATA", int'(bus.PB_DATA), 0);
        RESET_N = 1'b1;
        @(negedge VGA_CLK);
        check("ready after release", int'(bus.CMD_READY), 1);

        // 810..812, 970..972
        run_fill("small", 10, 5, 3, 2, 4'h3, 10, 12, 5, 6, 1'b0, a0);
        run_fill("full", 0, 0, 160, 120, 4'hA, 0, 159, 0, 119, 1'b0, a0);
        // only 19198, 19199
        run_fill("clip corner", 158, 119, 5, 4, 4'hF, 158, 159, 119, 119, 1'b0, a0);
        run_fill("clip bottom", 0, 118, 1, 5, 4'h7, 0, 0, 118, 119, 1'b0, a0);
        run_fill("empty w0", 5, 5, 0, 5, 4'h1, 1, 0, 1, 0, 1'b0, a0);
        run_fill("empty x200", 200, 0, 10, 10, 4'h2, 1, 0, 1, 0, 1'b0, a0);
        run_fill("empty h0", 5, 5, 5, 0, 4'h4, 1, 0, 1, 0, 1'b0, a0);

        // VALID held high with junk fields through a 4x4 fill.
        run_fill("held 1st", 20, 30, 4, 4, 4'h6, 20, 23, 30, 33, 1'b1, a0);
        run_fill("held 2nd", 50, 60, 4, 4, 4'h9, 50, 53, 60, 63, 1'b0, a1);
        check("held accept spacing", a1 - a0, 16 + 4);

        // Reset pulse while the 5th write of a 4x4 fill is on the port.
        t = 0;
        while (!bus.CMD_READY && t < 100) begin
            @(negedge VGA_CLK);
            t++;
        end
        drive_cmd(1, 1, 4, 4, 4'h5);
        @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        bus.CMD_VALID = 1'b0;
        scramble();
        nw = 0;
        last_wa = -1;
        for (t = 0; t < 20 && nw < 5; t++) begin
            @(negedge VGA_CLK);
            if (bus.PB_WE) begin
                nw++;
                last_wa = int'(bus.PB_WA);
            end
        end
        check("rst writes before", nw, 5);
        check("rst 5th addr", last_wa, 2 * 160 + 1);
        RESET_N = 1'b0;
        @(negedge VGA_CLK);
        check("rst PB_WE cleared", int'(bus.PB_WE), 0);
        check("rst DONE low", int'(bus.DONE), 0);
        check("rst ready low", int'(bus.CMD_READY), 0);
        RESET_N = 1'b1;
        @(negedge VGA_CLK);
        check("rst ready on release", int'(bus.CMD_READY), 1);
        we_cnt = 0;
        done_cnt = 0;
        repeat (30) begin
            @(negedge VGA_CLK);
            if (bus.PB_WE) we_cnt++;
            if (bus.DONE) done_cnt++;
        end
        check("rst no later writes", we_cnt, 0);
        check("rst no done", done_cnt, 0);
        run_fill("after rst", 100, 100, 2, 3, 4'hC, 100, 101, 100, 102, 1'b0, a0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
